// File: rtl/cpu_dbg_pkg.sv
// Shared debug-dump definitions: beat tags, dump FSM states
// and stream geometry for the CPU state dump streamer.
package cpu_dbg_pkg;

    localparam int NUM_REGS   = 32;
    localparam int MEM_WORDS  = 8;
    localparam int DATA_W     = 32;
    localparam int DUMP_BEATS = 1 + NUM_REGS + MEM_WORDS;

    localparam logic [1:0] TAG_PC  = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        REGS,
        MEM
    } state_e;

endpackage

// File: rtl/state_dump_streamer.sv
// Snapshots PC, then streams all registers and data-memory words
// as a tagged valid/ready word stream (PC, R0..R31, M0x00..M0x1c).
module state_dump_streamer
    import cpu_dbg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [4:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [4:0]        mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        out_tag_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [7:0]        drop_cnt_o
);

    localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
    localparam logic [4:0] LAST_MEM = 5'(MEM_WORDS - 1);

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        tag_q, tag_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [7:0]        drop_q;
    logic              xfer;

    assign xfer        = valid_q && out_ready_i;
    assign busy_o      = (state_q != IDLE);
    assign reg_addr_o  = (state_q == REGS) ? idx_q : 5'd0;
    assign mem_addr_o  = (state_q == MEM) ? {idx_q[2:0], 2'b00} : 5'd0;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_tag_o   = tag_q;
    assign out_last_o  = last_q;
    assign done_o      = done_q;
    assign drop_cnt_o  = drop_q;

    // State, index and output-beat registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            tag_q   <= TAG_PC;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next beat: a new word is loaded only when the held one transfers
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tag_d   = tag_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_i) begin
                    state_d = REGS;
                    idx_d   = '0;
                    data_d  = pc_i;
                    tag_d   = TAG_PC;
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            REGS: begin
                if (xfer) begin
                    data_d = reg_data_i;
                    tag_d  = TAG_REG;
                    idx_d  = idx_q + 5'd1;
                    if (idx_q == LAST_REG) begin
                        state_d = MEM;
                        idx_d   = '0;
                    end
                end
            end
            MEM: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                        tag_d   = TAG_PC;
                        last_d  = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = mem_data_i;
                        tag_d  = TAG_MEM;
                        last_d = (idx_q == LAST_MEM);
                        idx_d  = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of triggers ignored while a dump is running
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= '0;
        end else if (trig_i && busy_o && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_state_dump_streamer.sv
// Self-checking bench for state_dump_streamer: directed spot beats,
// backpressure, dropped triggers, reset mid-dump, random dumps.
module tb_state_dump_streamer;
    import cpu_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        trig_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_data_i;
    logic [4:0]  mem_addr_o;
    logic [31:0] mem_data_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic [1:0]  out_tag_o;
    logic        out_last_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  drop_cnt_o;

    logic [31:0] rf [32];
    logic [7:0]  mem_b [32];
    logic [31:0] got_d [DUMP_BEATS];
    logic [1:0]  got_t [DUMP_BEATS];
    logic        got_l [DUMP_BEATS];
    logic [31:0] cur_pc;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        int          beat;
        logic [1:0]  tag;
        logic [31:0] data;
        logic        last;
    } spot_t;
    spot_t spots [5];

    always #5 clk = ~clk;

    assign reg_data_i = rf[reg_addr_o];
    assign mem_data_i = {mem_b[int'(mem_addr_o) + 3], mem_b[int'(mem_addr_o) + 2],
                         mem_b[int'(mem_addr_o) + 1], mem_b[int'(mem_addr_o)]};

    state_dump_streamer dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .trig_i      (trig_i),
        .pc_i        (pc_i),
        .reg_addr_o  (reg_addr_o),
        .reg_data_i  (reg_data_i),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_tag_o   (out_tag_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected beat k straight from the dump order: PC, R0..R31, M0..M7
    function automatic logic [31:0] exp_data(int k);
        int a;
        if (k == 0) return cur_pc;
        if (k <= 32) return rf[k - 1];
        a = (k - 33) * 4;
        return {mem_b[a + 3], mem_b[a + 2], mem_b[a + 1], mem_b[a]};
    endfunction

    function automatic logic [1:0] exp_tag(int k);
        if (k == 0) return 2'd0;
        if (k <= 32) return 2'd1;
        return 2'd2;
    endfunction

    task automatic compare_all(input string nm);
        for (int k = 0; k < DUMP_BEATS; k++) begin
            chk($sformatf("%s_d%0d", nm, k), got_d[k], exp_data(k));
            chk($sformatf("%s_t%0d", nm, k), 32'(got_t[k]), 32'(exp_tag(k)));
            chk($sformatf("%s_l%0d", nm, k), 32'(got_l[k]), 32'(k == DUMP_BEATS - 1));
        end
    endtask

    task automatic start(input logic [31:0] pc);
        cur_pc = pc;
        trig_i = 1'b1;
        pc_i   = pc;
        @(posedge clk);
        @(negedge clk);
        trig_i = 1'b0;
        pc_i   = $urandom;
        chk("start_valid", 32'(out_valid_o), 32'd1);
        chk("start_tag", 32'(out_tag_o), 32'd0);
        chk("start_data", out_data_o, pc);
        chk("start_busy", 32'(busy_o), 32'd1);
    endtask

    // mode 0: ready=1, 1: 1,0,0,1 pattern, 2: random, 3: stall at beat5 and change R5
    task automatic collect(input int mode, input bit inj, input int stop_at);
        int          cnt = 0;
        int          cyc = 0;
        int          st = 0;
        bit          rdy;
        bit          pstall = 0;
        logic [31:0] pd = '0;
        logic [1:0]  pt = '0;
        logic        pl = 1'b0;
        while (cnt < stop_at && cyc < 400) begin
            chk("valid_hold", 32'(out_valid_o), 32'd1);
            if (pstall) begin
                chk("stall_data", out_data_o, pd);
                chk("stall_tag", 32'(out_tag_o), 32'(pt));
                chk("stall_last", 32'(out_last_o), 32'(pl));
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(cnt == 5 && st < 2);
                    if (!rdy) begin
                        rf[5] = 32'd9;
                        st++;
                    end
                end
            endcase
            out_ready_i = rdy;
            trig_i = inj && (cnt == 5 || cnt == 15 || cnt == 25 || cnt == 40);
            if (out_valid_o && rdy) begin
                got_d[cnt] = out_data_o;
                got_t[cnt] = out_tag_o;
                got_l[cnt] = out_last_o;
                cnt++;
            end
            pstall = out_valid_o && !rdy;
            pd = out_data_o;
            pt = out_tag_o;
            pl = out_last_o;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        trig_i = 1'b0;
        if (cnt < stop_at) chk("beat_timeout", 32'(cnt), 32'(stop_at));
        if (stop_at == DUMP_BEATS) begin
            chk("done_pulse", 32'(done_o), 32'd1);
            chk("done_valid", 32'(out_valid_o), 32'd0);
            chk("done_busy", 32'(busy_o), 32'd0);
            chk("done_last", 32'(out_last_o), 32'd0);
        end
    endtask

    task automatic after_done();
        @(posedge clk);
        @(negedge clk);
        chk("done_once", 32'(done_o), 32'd0);
        chk("idle_valid", 32'(out_valid_o), 32'd0);
    endtask

    task automatic randomize_state();
        for (int i = 0; i < 32; i++) begin
            rf[i]    = $urandom;
            mem_b[i] = 8'($urandom);
        end
    endtask

    initial begin
        logic [7:0] d0;
        for (int i = 0; i < 32; i++) begin
            rf[i]    = 32'h0100_0000 + 32'(i * 3);
            mem_b[i] = 8'(i);
        end
        rf[8]    = 32'd5;
        rf[31]   = 32'hFFFF_FFFF;
        mem_b[0] = 8'h78;
        mem_b[1] = 8'h56;
        mem_b[2] = 8'h34;
        mem_b[3] = 8'h12;
        spots[0] = '{0, 2'd0, 32'h0000_0010, 1'b0};
        spots[1] = '{9, 2'd1, 32'h0000_0005, 1'b0};
        spots[2] = '{32, 2'd1, 32'hFFFF_FFFF, 1'b0};
        spots[3] = '{33, 2'd2, 32'h1234_5678, 1'b0};
        spots[4] = '{40, 2'd2, 32'h1F1E_1D1C, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_tag", 32'(out_tag_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_raddr", 32'(reg_addr_o), 32'd0);
        chk("rst_maddr", 32'(mem_addr_o), 32'd0);

        start(32'h0000_0010);
        collect(0, 1'b0, DUMP_BEATS);
        after_done();
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("spot%0d_tag", s), 32'(got_t[spots[s].beat]), 32'(spots[s].tag));
            chk($sformatf("spot%0d_data", s), got_d[spots[s].beat], spots[s].data);
            chk($sformatf("spot%0d_last", s), 32'(got_l[spots[s].beat]), 32'(spots[s].last));
        end
        compare_all("direct");

        start(32'h0000_1234);
        collect(1, 1'b0, DUMP_BEATS);
        after_done();
        compare_all("bp");

        start(32'hCAFE_0000);
        collect(0, 1'b1, DUMP_BEATS);
        after_done();
        compare_all("drop");
        chk("drop_four", 32'(drop_cnt_o), 32'd4);

        out_ready_i = 1'b0;
        start(32'hBEEF_0001);
        out_ready_i = 1'b0;
        trig_i = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        trig_i = 1'b0;
        chk("drop_sat", 32'(drop_cnt_o), 32'd255);
        chk("sat_hold_data", out_data_o, 32'hBEEF_0001);
        collect(0, 1'b0, DUMP_BEATS);
        after_done();
        compare_all("sat");

        start(32'h0000_0ABC);
        collect(0, 1'b0, 21);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        chk("mrst_valid", 32'(out_valid_o), 32'd0);
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_drop", 32'(drop_cnt_o), 32'd0);
        chk("mrst_done", 32'(done_o), 32'd0);
        chk("mrst_last", 32'(out_last_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_done2", 32'(done_o), 32'd0);
        start(32'h0000_0DEF);
        collect(2, 1'b0, DUMP_BEATS);
        d0 = drop_cnt_o;
        start(32'h7777_0000);
        chk("redone_drop", 32'(drop_cnt_o), 32'(d0));
        chk("redone_done", 32'(done_o), 32'd0);
        collect(0, 1'b0, DUMP_BEATS);
        after_done();
        compare_all("redone");

        rf[5] = 32'd7;
        start(32'h0000_0555);
        collect(3, 1'b0, DUMP_BEATS);
        after_done();
        chk("live_r5", got_d[6], 32'd9);
        compare_all("live");

        for (int n = 0; n < 4; n++) begin
            randomize_state();
            start($urandom);
            collect(2, 1'b0, DUMP_BEATS);
            after_done();
            compare_all($sformatf("rnd%0d", n));
        end
        chk("final_drop", 32'(drop_cnt_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
